sysid_reader: RTL and testbench

SYSID_READER -- requirements
Module: sysid_reader

---
 rtl/sysid_reader_if.sv | 21 ++
 rtl/sysid_reader.sv | 160 ++++++++++++++++
 tb/tb_sysid_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_reader_if.sv
// Avalon-MM read-only master/slave bundle (word address, read strobe, stall, read data).
interface sysid_reader_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_reader.sv
// Reads the system-ID and timestamp words over Avalon-MM and compares them against the expected values.
// Latency: start at edge N -> RD_ID N+1, RD_TS N+2, done N+3 (plus one cycle per waitrequest stall).
// Backpressure: holds address/read while waitrequest=1; optional stall watchdog under SYSID_READER_TIMEOUT_EN.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1486166856,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    sysid_reader_if.master avm,
    output logic           busy,
    output logic           done,
    output logic [31:0]    id_value,
    output logic [31:0]    ts_value,
    output logic           id_ok,
    output logic           ts_ok,
    output logic           timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        rd_active;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_reader: TIMEOUT_CYCLES must be in 1..65535");
    end

    // Bus outputs decode straight from state so an async reset drops the read strobe at once.
    assign rd_active       = (state_q == RD_ID) || (state_q == RD_TS);
    assign avm.avm_read    = rd_active;
    assign avm.avm_address = (state_q == RD_TS);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;

`ifdef SYSID_READER_TIMEOUT_EN
    localparam logic [16:0] STALL_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] stall_q, stall_d;
    logic        stall_expired;
    logic        timeout_q, timeout_d;

    // True on the stalled cycle that would bring the count up to the limit.
    assign stall_expired = ({1'b0, stall_q} + 17'd1) >= STALL_LIMIT;
    assign timeout       = timeout_q;

    always_comb begin
        stall_d = stall_q;
        if (rd_active && avm.avm_waitrequest) begin
            stall_d = stall_q + 16'd1;
        end
        if ((state_d != state_q) && ((state_d == RD_ID) || (state_d == RD_TS))) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
`ifdef SYSID_READER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
`ifdef SYSID_READER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            RD_ID: begin
                if (!avm.avm_waitrequest) begin
                    id_value_d = avm.avm_readdata;
                    id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
                    state_d    = RD_TS;
                end
`ifdef SYSID_READER_TIMEOUT_EN
                else if (stall_expired) begin
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    state_d   = FIN;
                end
`endif
            end
            RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    ts_value_d = avm.avm_readdata;
                    ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
                    state_d    = FIN;
                end
`ifdef SYSID_READER_TIMEOUT_EN
                else if (stall_expired) begin
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    state_d   = FIN;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: zero-latency Avalon slave model with a controllable stall.
module tb_sysid_reader;

    localparam logic [31:0] TS_GOOD = 32'd1486166856;

    logic        clock;
    logic        reset;
    logic        start;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic        wreq;
    logic [31:0] id_word, ts_word;
    int          checks;
    int          errors;

    sysid_reader_if bus ();

    assign bus.avm_waitrequest = wreq;
    assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

    sysid_reader #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .avm      (bus.master),
        .busy     (busy),
        .done     (done),
        .id_value (id_value),
        .ts_value (ts_value),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulses start and counts cycles until done (1 = first cycle after the sampling edge).
    task automatic run_seq(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        wreq  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.avm_read, bus.avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.avm_read, bus.avm_address, busy, done, id_ok, ts_ok, timeout});
        end
        checks++;
        if ({id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {id_value, ts_value});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, bus.avm_read} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 00", {busy, bus.avm_read});
        end
    endtask

    task automatic test_nominal();
        id_word = 32'h0;
        ts_word = TS_GOOD;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checks++;
        if ({bus.avm_read, bus.avm_address, busy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL nominal_rd_id: got %b expected 1010",
                     {bus.avm_read, bus.avm_address, busy, done});
        end
        tick();
        checks++;
        if ({bus.avm_read, bus.avm_address, busy, done} !== 4'b1110) begin
            errors++;
            $display("FAIL nominal_rd_ts: got %b expected 1110",
                     {bus.avm_read, bus.avm_address, busy, done});
        end
        tick();
        checks++;
        if ({bus.avm_read, busy, done, id_ok, ts_ok, timeout} !== 6'b011110) begin
            errors++;
            $display("FAIL nominal_fin: got %b expected 011110",
                     {bus.avm_read, busy, done, id_ok, ts_ok, timeout});
        end
        checks++;
        if ({id_value, ts_value} !== {32'h0, TS_GOOD}) begin
            errors++;
            $display("FAIL nominal_values: got %h expected %h", {id_value, ts_value}, {32'h0, TS_GOOD});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL nominal_back_idle: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_bad_id();
        int cyc;
        id_word = 32'h5;
        ts_word = TS_GOOD;
        run_seq(cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL bad_id_latency: got %0d expected 3", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, id_value} !== {2'b01, 32'h5}) begin
            errors++;
            $display("FAIL bad_id_result: got %b/%h expected 01/00000005", {id_ok, ts_ok}, id_value);
        end
        tick();
    endtask

    task automatic test_hold();
        int cyc;
        id_word = 32'h7;
        ts_word = 32'h0;
        repeat (5) tick();
        checks++;
        if ({id_ok, ts_ok, id_value, ts_value} !== {2'b01, 32'h5, TS_GOOD}) begin
            errors++;
            $display("FAIL hold_idle: got %b/%h/%h expected 01/00000005/%h",
                     {id_ok, ts_ok}, id_value, ts_value, TS_GOOD);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({id_ok, ts_ok, id_value, ts_value} !== {2'b00, 32'h5, TS_GOOD}) begin
            errors++;
            $display("FAIL hold_start_clears_flags_only: got %b/%h/%h expected 00/00000005/%h",
                     {id_ok, ts_ok}, id_value, ts_value, TS_GOOD);
        end
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if ({cyc[3:0], id_ok, ts_ok, id_value, ts_value} !== {4'd3, 2'b00, 32'h7, 32'h0}) begin
            errors++;
            $display("FAIL hold_recapture: got cyc=%0d ok=%b id=%h ts=%h expected cyc=3 ok=00 id=7 ts=0",
                     cyc, {id_ok, ts_ok}, id_value, ts_value);
        end
        tick();
    endtask

    task automatic test_stall();
        int cyc;
        id_word = 32'h0;
        ts_word = TS_GOOD;
        wreq    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({bus.avm_read, bus.avm_address, busy, id_value} !== {3'b101, 32'h7}) begin
                errors++;
                $display("FAIL stall_hold_c%0d: got %b/%h expected 101/00000007",
                         k, {bus.avm_read, bus.avm_address, busy}, id_value);
            end
            tick();
        end
        wreq = 1'b0;
        cyc  = 5;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 7) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected 7", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, id_value} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL stall_result: got %b/%h expected 11/00000000", {id_ok, ts_ok}, id_value);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ndone;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 1", done);
        end
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_fin_start_ignored: got %b expected 00", {busy, done});
        end
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL b2b_no_second_seq: got %0d busy/done cycles expected 0", ndone);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        wreq = 1'b1;
`ifdef SYSID_READER_TIMEOUT_EN
        run_seq(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 9", cyc);
        end
        checks++;
        if ({timeout, id_ok, ts_ok} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_flags: got %b expected 100", {timeout, id_ok, ts_ok});
        end
        tick();
        wreq  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared: got %b expected 0", timeout);
        end
`else
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) cyc++;
        end
        checks++;
        if ({cyc[3:0], busy, bus.avm_read, timeout} !== {4'd0, 3'b110}) begin
            errors++;
            $display("FAIL stall_forever: got dones=%0d busy/read/timeout=%b expected 0/110",
                     cyc, {busy, bus.avm_read, timeout});
        end
        wreq = 1'b0;
`endif
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if ({done, id_ok, ts_ok, timeout} !== 4'b1110) begin
            errors++;
            $display("FAIL timeout_recover: got %b expected 1110", {done, id_ok, ts_ok, timeout});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int nact;
        wreq  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({bus.avm_read, bus.avm_address} !== 2'b11) begin
            errors++;
            $display("FAIL mid_in_rd_ts: got %b expected 11", {bus.avm_read, bus.avm_address});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.avm_read, bus.avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL mid_async_ctrl: got %b expected 0000000",
                     {bus.avm_read, bus.avm_address, busy, done, id_ok, ts_ok, timeout});
        end
        checks++;
        if ({id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL mid_async_values: got %h expected 0", {id_value, ts_value});
        end
        tick();
        reset = 1'b0;
        nact  = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy || bus.avm_read) nact++;
        end
        checks++;
        if (nact !== 0) begin
            errors++;
            $display("FAIL mid_no_restart: got %0d active cycles expected 0", nact);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        wreq    = 1'b0;
        id_word = 32'h0;
        ts_word = TS_GOOD;
        test_reset();
        test_nominal();
        test_bad_id();
        test_hold();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
